// File: rtl/trace_reorder_queue.sv
// trace_reorder_queue: fixed-offset reorder queue for trace events.
// Producers drop completion events into slots measured from the head.
// The array shifts one slot toward the head whenever the head is empty or
// consumed, so events leave in issue order regardless of pipeline length.
// Slot numbers on the insert/invalidate ports always name positions as they
// stand after the current edge's shift.
module trace_reorder_queue #(
    parameter int DEPTH       = 7,
    parameter int NUM_PORTS   = 3,
    parameter int ENTRY_WIDTH = 64,
    parameter int SLOT_W      = $clog2(DEPTH)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_PORTS-1:0]             insert_en,
    input  logic [NUM_PORTS*SLOT_W-1:0]      insert_slot,
    input  logic [NUM_PORTS*ENTRY_WIDTH-1:0] insert_data,
    input  logic                             invalidate_en,
    input  logic [SLOT_W-1:0]                invalidate_slot,
    output logic                             out_valid,
    output logic [ENTRY_WIDTH-1:0]           out_data,
    input  logic                             out_ready,
    output logic                             stall,
    output logic                             collision_err,
    output logic [15:0]                      collision_count,
    output logic [31:0]                      event_count
);

    // Wide enough to hold 0..NUM_PORTS collisions in one cycle.
    localparam int CNT_W = $clog2(NUM_PORTS + 1);

    logic [DEPTH-1:0]       r_valid;
    logic [ENTRY_WIDTH-1:0] r_data [DEPTH];
    logic                   r_coll_err;
    logic [15:0]            r_coll_count;
    logic [31:0]            r_event_count;

    logic                   w_advance;
    logic                   w_accept;
    logic [DEPTH-1:0]       w_valid_n;
    logic [ENTRY_WIDTH-1:0] w_data_n [DEPTH];
    logic [CNT_W-1:0]       w_coll_cnt;
    logic                   w_slot_hit;
    logic [16:0]            w_coll_sum;
    logic [15:0]            w_coll_count_n;

    assign w_advance = !r_valid[0] || out_ready;
    assign w_accept  = r_valid[0] && out_ready;

    // Next slot array: shift, then inserts in port order, then invalidate.
    always_comb begin
        w_valid_n  = r_valid;
        w_data_n   = r_data;
        w_coll_cnt = {CNT_W{1'b0}};
        w_slot_hit = 1'b0;

        if (w_advance) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                w_valid_n[i] = r_valid[i+1];
                w_data_n[i]  = r_data[i+1];
            end
            w_valid_n[DEPTH-1] = 1'b0;
            w_data_n[DEPTH-1]  = {ENTRY_WIDTH{1'b0}};
        end else begin
            w_valid_n = r_valid;
            w_data_n  = r_data;
        end

        // A slot already valid (shifted in, or claimed by a lower port)
        // keeps its occupant; a slot index past the end matches nothing.
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (insert_en[p]) begin
                w_slot_hit = 1'b0;
                for (int s = 0; s < DEPTH; s++) begin
                    if (insert_slot[p*SLOT_W +: SLOT_W] == SLOT_W'(s)) begin
                        w_slot_hit = 1'b1;
                        if (w_valid_n[s]) begin
                            w_coll_cnt = w_coll_cnt + CNT_W'(1);
                        end else begin
                            w_valid_n[s] = 1'b1;
                            w_data_n[s]  = insert_data[p*ENTRY_WIDTH +: ENTRY_WIDTH];
                        end
                    end else begin
                        w_slot_hit = w_slot_hit;
                    end
                end
                if (!w_slot_hit) begin
                    w_coll_cnt = w_coll_cnt + CNT_W'(1);
                end else begin
                    w_coll_cnt = w_coll_cnt;
                end
            end else begin
                w_coll_cnt = w_coll_cnt;
            end
        end

        // Invalidate runs last so it also kills a same-cycle insert.
        for (int s = 0; s < DEPTH; s++) begin
            if (invalidate_en && (invalidate_slot == SLOT_W'(s))) begin
                w_valid_n[s] = 1'b0;
            end else begin
                w_valid_n[s] = w_valid_n[s];
            end
        end
    end

    // Saturating collision accumulate; a 17-bit sum exposes the overflow.
    always_comb begin
        w_coll_sum = {1'b0, r_coll_count} + 17'(w_coll_cnt);
        if (w_coll_sum[16]) begin
            w_coll_count_n = 16'hFFFF;
        end else begin
            w_coll_count_n = w_coll_sum[15:0];
        end
    end

    // Slot array register; reset empties every slot and zeroes payloads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= {ENTRY_WIDTH{1'b0}};
            end
        end else begin
            r_valid <= w_valid_n;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= w_data_n[i];
            end
        end
    end

    // Sticky collision flag, saturating collision count, wrapping event count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_coll_err    <= 1'b0;
            r_coll_count  <= 16'h0000;
            r_event_count <= 32'h0000_0000;
        end else begin
            if (w_coll_cnt != {CNT_W{1'b0}}) begin
                r_coll_err <= 1'b1;
            end else begin
                r_coll_err <= r_coll_err;
            end
            r_coll_count <= w_coll_count_n;
            if (w_accept) begin
                r_event_count <= r_event_count + 32'd1;
            end else begin
                r_event_count <= r_event_count;
            end
        end
    end

    assign out_valid       = r_valid[0];
    assign out_data        = r_data[0];
    assign stall           = r_valid[0] && !out_ready;
    assign collision_err   = r_coll_err;
    assign collision_count = r_coll_count;
    assign event_count     = r_event_count;

endmodule

// File: tb/tb_trace_reorder_queue.sv
// Self-checking bench for trace_reorder_queue: a cycle table of inputs and
// expected head/counter values, plus hand sequences for mid-cycle reset and
// collision-count saturation.
module tb_trace_reorder_queue;

    logic         clk;
    logic         reset_n;
    logic [2:0]   insert_en;
    logic [8:0]   insert_slot;
    logic [191:0] insert_data;
    logic         invalidate_en;
    logic [2:0]   invalidate_slot;
    logic         out_valid;
    logic [63:0]  out_data;
    logic         out_ready;
    logic         stall;
    logic         collision_err;
    logic [15:0]  collision_count;
    logic [31:0]  event_count;

    int n_tests = 0;
    int n_fail  = 0;

    trace_reorder_queue #(
        .DEPTH(7), .NUM_PORTS(3), .ENTRY_WIDTH(64)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .insert_en(insert_en), .insert_slot(insert_slot), .insert_data(insert_data),
        .invalidate_en(invalidate_en), .invalidate_slot(invalidate_slot),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .stall(stall), .collision_err(collision_err),
        .collision_count(collision_count), .event_count(event_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  en;
        logic [2:0]  s0, s1, s2;
        logic [63:0] d0, d1, d2;
        logic        inv_en;
        logic [2:0]  inv_s;
        logic        rdy;
        logic        e_v;
        logic [63:0] e_d;
        logic        e_stall;
        logic        e_err;
        logic [15:0] e_cc;
        logic [31:0] e_ev;
    } vec_t;

    localparam int NV = 33;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic [2:0] en, input logic [2:0] s0, input logic [63:0] d0,
        input logic [2:0] s1, input logic [63:0] d1,
        input logic [2:0] s2, input logic [63:0] d2,
        input logic inv_en, input logic [2:0] inv_s, input logic rdy,
        input logic e_v, input logic [63:0] e_d, input logic e_stall,
        input logic e_err, input logic [15:0] e_cc, input logic [31:0] e_ev);
        vec_t v;
        v.en = en; v.s0 = s0; v.s1 = s1; v.s2 = s2;
        v.d0 = d0; v.d1 = d1; v.d2 = d2;
        v.inv_en = inv_en; v.inv_s = inv_s; v.rdy = rdy;
        v.e_v = e_v; v.e_d = e_d; v.e_stall = e_stall;
        v.e_err = e_err; v.e_cc = e_cc; v.e_ev = e_ev;
        return v;
    endfunction

    // Idle cycle: no insert, no invalidate, given ready and expectations.
    function automatic vec_t idle(
        input logic rdy, input logic e_v, input logic [63:0] e_d, input logic e_stall,
        input logic e_err, input logic [15:0] e_cc, input logic [31:0] e_ev);
        return mk(3'b000, 3'd0, 64'h0, 3'd0, 64'h0, 3'd0, 64'h0, 1'b0, 3'd0, rdy,
                  e_v, e_d, e_stall, e_err, e_cc, e_ev);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle(input logic rdy);
        insert_en       = 3'b000;
        insert_slot     = 9'd0;
        insert_data     = 192'd0;
        invalidate_en   = 1'b0;
        invalidate_slot = 3'd0;
        out_ready       = rdy;
    endtask

    initial begin
        // Ordering: C at cycle 3, A at 5, B at 6.
        vecs[0]  = mk(3'b001, 3'd4, 64'hA, 3'd0, 64'h0, 3'd0, 64'h0, 1'b0, 3'd0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 16'd0, 32'd0);
        vecs[1]  = mk(3'b010, 3'd0, 64'h0, 3'd4, 64'hB, 3'd0, 64'h0, 1'b0, 3'd0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 16'd0, 32'd0);
        vecs[2]  = mk(3'b100, 3'd0, 64'h0, 3'd0, 64'h0, 3'd0, 64'hC, 1'b0, 3'd0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 16'd0, 32'd0);
        vecs[3]  = idle(1'b1, 1'b1, 64'hC, 1'b0, 1'b0, 16'd0, 32'd0);
        vecs[4]  = idle(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 16'd0, 32'd1);
        vecs[5]  = idle(1'b1, 1'b1, 64'hA, 1'b0, 1'b0, 16'd0, 32'd1);
        vecs[6]  = idle(1'b1, 1'b1, 64'hB, 1'b0, 1'b0, 16'd0, 32'd2);
        // Collision: ports 0 and 2 on slot 2; port 0 wins, out 3 cycles later.
        vecs[7]  = mk(3'b101, 3'd2, 64'h11, 3'd0, 64'h0, 3'd2, 64'h22, 1'b0, 3'd0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 16'd0, 32'd3);
        vecs[8]  = idle(1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 16'd1, 32'd3);
        vecs[9]  = idle(1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 16'd1, 32'd3);
        vecs[10] = idle(1'b1, 1'b1, 64'h11, 1'b0, 1'b1, 16'd1, 32'd3);
        // Invalidate kills same-cycle insert to slot 4; nothing emerges.
        vecs[11] = mk(3'b010, 3'd0, 64'h0, 3'd4, 64'h55, 3'd0, 64'h0, 1'b1, 3'd4, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 16'd1, 32'd4);
        for (int i = 12; i <= 16; i++) begin
            vecs[i] = idle(1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 16'd1, 32'd4);
        end
        // Backpressure: fill 0..2 with 1,2,3, hold ready low for 5 cycles.
        vecs[17] = mk(3'b111, 3'd0, 64'h1, 3'd1, 64'h2, 3'd2, 64'h3, 1'b0, 3'd0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 16'd1, 32'd4);
        for (int i = 18; i <= 22; i++) begin
            vecs[i] = idle(1'b0, 1'b1, 64'h1, 1'b1, 1'b1, 16'd1, 32'd4);
        end
        vecs[23] = idle(1'b1, 1'b1, 64'h1, 1'b0, 1'b1, 16'd1, 32'd4);
        vecs[24] = idle(1'b1, 1'b1, 64'h2, 1'b0, 1'b1, 16'd1, 32'd5);
        vecs[25] = idle(1'b1, 1'b1, 64'h3, 1'b0, 1'b1, 16'd1, 32'd6);
        // Out-of-range slot counts as a collision.
        vecs[26] = mk(3'b001, 3'd7, 64'h99, 3'd0, 64'h0, 3'd0, 64'h0, 1'b0, 3'd0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 16'd1, 32'd7);
        // Insert onto a slot made valid by the shift: earlier occupant wins.
        vecs[27] = mk(3'b001, 3'd3, 64'h77, 3'd0, 64'h0, 3'd0, 64'h0, 1'b0, 3'd0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 16'd2, 32'd7);
        vecs[28] = mk(3'b010, 3'd0, 64'h0, 3'd2, 64'h88, 3'd0, 64'h0, 1'b0, 3'd0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 16'd2, 32'd7);
        vecs[29] = idle(1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 16'd3, 32'd7);
        vecs[30] = idle(1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 16'd3, 32'd7);
        vecs[31] = idle(1'b1, 1'b1, 64'h77, 1'b0, 1'b1, 16'd3, 32'd7);
        vecs[32] = idle(1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 16'd3, 32'd8);

        // Reset state.
        reset_n = 1'b0;
        set_idle(1'b1);
        #2;
        chk("reset out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset out_data", out_data, 64'd0);
        chk("reset stall", {63'd0, stall}, 64'd0);
        chk("reset collision_err", {63'd0, collision_err}, 64'd0);
        chk("reset collision_count", {48'd0, collision_count}, 64'd0);
        chk("reset event_count", {32'd0, event_count}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Table: inputs applied after negedge, outputs checked in the same cycle.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            insert_en       = vecs[i].en;
            insert_slot     = {vecs[i].s2, vecs[i].s1, vecs[i].s0};
            insert_data     = {vecs[i].d2, vecs[i].d1, vecs[i].d0};
            invalidate_en   = vecs[i].inv_en;
            invalidate_slot = vecs[i].inv_s;
            out_ready       = vecs[i].rdy;
            #1;
            chk($sformatf("row%0d out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].e_v});
            if (vecs[i].e_v) begin
                chk($sformatf("row%0d out_data", i), out_data, vecs[i].e_d);
            end
            chk($sformatf("row%0d stall", i), {63'd0, stall}, {63'd0, vecs[i].e_stall});
            chk($sformatf("row%0d collision_err", i), {63'd0, collision_err}, {63'd0, vecs[i].e_err});
            chk($sformatf("row%0d collision_count", i), {48'd0, collision_count}, {48'd0, vecs[i].e_cc});
            chk($sformatf("row%0d event_count", i), {32'd0, event_count}, {32'd0, vecs[i].e_ev});
        end

        // Reset mid-operation with four queued events.
        @(negedge clk);
        insert_en   = 3'b111;
        insert_slot = {3'd2, 3'd1, 3'd0};
        insert_data = {64'hD2, 64'hD1, 64'hD0};
        out_ready   = 1'b1;
        @(negedge clk);
        insert_en   = 3'b001;
        insert_slot = {3'd0, 3'd0, 3'd3};
        insert_data = {64'h0, 64'h0, 64'hD3};
        out_ready   = 1'b0;
        #1;
        chk("prereset out_data", out_data, 64'hD0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset out_valid", {63'd0, out_valid}, 64'd0);
        chk("midreset out_data", out_data, 64'd0);
        chk("midreset stall", {63'd0, stall}, 64'd0);
        chk("midreset collision_err", {63'd0, collision_err}, 64'd0);
        chk("midreset collision_count", {48'd0, collision_count}, 64'd0);
        chk("midreset event_count", {32'd0, event_count}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        set_idle(1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("postreset%0d out_valid", k), {63'd0, out_valid}, 64'd0);
        end
        chk("postreset event_count", {32'd0, event_count}, 64'd0);

        // Saturation: three out-of-range inserts per cycle.
        @(negedge clk);
        insert_en   = 3'b111;
        insert_slot = {3'd7, 3'd7, 3'd7};
        repeat (21844) @(posedge clk);
        @(negedge clk);
        #1;
        chk("sat pre count", {48'd0, collision_count}, 64'd65532);
        @(negedge clk);
        #1;
        chk("sat edge count", {48'd0, collision_count}, 64'hFFFF);
        repeat (1500) @(negedge clk);
        #1;
        chk("sat final count", {48'd0, collision_count}, 64'hFFFF);
        chk("sat collision_err", {63'd0, collision_err}, 64'd1);
        chk("sat out_valid", {63'd0, out_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
